seg7_bcd_capture: RTL and testbench
===================================

# seg7_bcd_capture

Sequential 7-segment-to-BCD decoder: the receive end of the team's BCD-to-7-segment encoder path. It samples a multiplexed 4-digit segment bus, qualifies each digit's pattern for stability, and decodes it back to BCD. It sits at a display-monitor or loopback point, so encoder output can be checked in-system and a scanned display's content can be reconstructed.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (legal range 2..255).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s  in  7  segment lines, active-high; s[6]=a, s[5]=b, s[4]=c, s[3]=d, s[2]=e, s[1]=f, s[0]=g
- an  in  4  digit enables, active-high, one-hot when valid; an[i] selects digit i
- digits  out  16  decoded BCD; digits[4i+3:4i] belongs to digit i
- valid  out  4  valid[i]=1 when digits field i holds a legally decoded pattern
- err  out  4  err[i]=1 when the last capture on digit i was an illegal pattern
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse

## Operation
- Legal patterns (s[6:0]) and the digit each decodes to:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - 0000000→blank, which decodes to 4'hF with valid=1 and err=0
- Any other pattern is illegal.
- The input pair {an, s} is registered every cycle (the sample register).
- Dwell counter:
  - Increments, saturating, when the current sample equals the previous sample and an is one-hot.
  - Clears to 0 in every other case: a change, zero-hot an, or multi-hot an.
- Capture fires exactly once per dwell, when the counter reaches STABLE_CYCLES-1 (STABLE_CYCLES identical one-hot samples). A captured flag blocks re-capture until {an, s} changes.
- Capture to digit i on a legal pattern: update digits field i, set valid[i]=1, err[i]=0.
- Capture to digit i on an illegal pattern: keep digits field i, set valid[i]=0, err[i]=1.
- Frame tracking:
  - Capture mask seen[3:0]: each capture sets seen[i]. A repeat capture of the same digit is harmless.
  - When seen would become 4'b1111: frame_done=1 for one cycle, and seen clears to 0000 in the same cycle.
  - The capture that completes the mask is not carried into the next frame.
- States: IDLE (counter=0, no one-hot input) → DWELL (counting) → HELD (captured, waiting for change) → back to DWELL or IDLE on change. HELD is required; re-capture while held is illegal.

## Timing
- Reset (rst=1 at a clk edge):
  - Outputs: digits=16'hFFFF, valid=0000, err=0000, frame_done=0.
  - Internal: seen=0000, counter=0, sample register cleared to an=0000.
- Latency: digits, valid and err update on the clock edge one cycle after the STABLE_CYCLES-th identical input sample is registered. With STABLE_CYCLES=4, a pattern applied before edge 1 is visible after edge 5.
- frame_done asserts in the same cycle as the completing digit's output update.
- Counter width is $clog2(STABLE_CYCLES) bits and saturates; a long dwell does not wrap and does not re-capture.
- If an changes to another one-hot value with the same s, the dwell restarts for the new digit.
- Reset mid-dwell or mid-frame aborts everything. No capture occurs on the reset edge, and the counter restarts from 0 afterwards.
- Glitches shorter than STABLE_CYCLES samples never reach the outputs.

## Test plan
- Reset: assert rst 2 cycles → digits=16'hFFFF, valid=0000, err=0000, frame_done=0.
- Full frame: scan digits 0..3 with patterns for 1, 2, 3, 4, each held 6 cycles (STABLE_CYCLES=4) → digits=16'h4321, valid=1111, exactly one frame_done pulse at the digit-3 update, and no second capture per dwell.
- Encoder loopback: drive all bcd 0..15 through the encoder into digit 0 → 0..9 decode exactly. Encoder outputs for 10..15 must set err[0]=1 and valid[0]=0 unless the encoder emits blank, in which case digit 0=4'hF and valid[0]=1.
- Glitch rejection: digit 2 holds pattern for 7 for 3 cycles, then pattern for 8 for 5 cycles → digit 2 captures 8 only, and only 1 capture occurs.
- Bad enables: an=0000 or 0011 with a legal s for 10 cycles → no output change. Then an=0001 with s=1111110 held 4 cycles → digit 0=0 after the expected latency.
- Reset mid-operation: rst asserted after 3 of 4 dwell cycles and after a 3-digit partial frame → no capture. A subsequent full 4-digit scan yields a single frame_done.

Source files
------------

// File: rtl/seg7_bcd_capture.sv
// Receive end of the 7-segment path: samples a scanned 4-digit segment bus,
// waits for each digit pattern to dwell, then decodes it back to BCD.
module seg7_bcd_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  s,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       an_p0;
  logic [6:0]       s_p0;
  logic [3:0]       seen;
  logic             in_onehot, stable, capture;
  logic [4:0]       dec_p0;
  logic [1:0]       idx_p0;
  logic [3:0]       seen_set;

  // {legal, bcd}; blank decodes to F and still counts as legal
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_decode = 5'b1_0000;
      7'b0110000: seg_decode = 5'b1_0001;
      7'b1101101: seg_decode = 5'b1_0010;
      7'b1111001: seg_decode = 5'b1_0011;
      7'b0110011: seg_decode = 5'b1_0100;
      7'b1011011: seg_decode = 5'b1_0101;
      7'b1011111: seg_decode = 5'b1_0110;
      7'b1110000: seg_decode = 5'b1_0111;
      7'b1111111: seg_decode = 5'b1_1000;
      7'b1111011: seg_decode = 5'b1_1001;
      7'b0000000: seg_decode = 5'b1_1111;
      default:    seg_decode = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] a);
    case (a)
      4'b0010: onehot_index = 2'd1;
      4'b0100: onehot_index = 2'd2;
      4'b1000: onehot_index = 2'd3;
      default: onehot_index = 2'd0;
    endcase
  endfunction

  always_comb begin
    in_onehot = $onehot(an);
    stable    = in_onehot && (an == an_p0) && (s == s_p0);
    capture   = (state == DWELL) && (cnt == CNT_MAX);
    dec_p0    = seg_decode(s_p0);
    idx_p0    = onehot_index(an_p0);
    seen_set  = seen | (4'b0001 << idx_p0);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!stable) begin
      cnt_n   = '0;
      state_n = in_onehot ? DWELL : IDLE;
    end else begin
      if (cnt != CNT_MAX) cnt_n = cnt + CNT_W'(1);
      if (capture) state_n = HELD;
    end
  end

  // stage p0: sample register and dwell tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      an_p0 <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      an_p0 <= an;
    end
  end

  always_ff @(posedge clk) begin
    s_p0 <= s;
  end

  // stage p1: decoded capture into the digit fields and frame mask
  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= 16'hFFFF;
      valid      <= 4'b0000;
      err        <= 4'b0000;
      seen       <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        if (dec_p0[4]) begin
          digits[{idx_p0, 2'b00} +: 4] <= dec_p0[3:0];
          valid[idx_p0] <= 1'b1;
          err[idx_p0]   <= 1'b0;
        end else begin
          valid[idx_p0] <= 1'b0;
          err[idx_p0]   <= 1'b1;
        end
        if (seen_set == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= 4'b0000;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Randomized and directed bench for seg7_bcd_capture against a run-length
// behavioural model of the dwell/capture/frame rules.
module tb_seg7_bcd_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  s   = 7'd0;
  logic [3:0]  an  = 4'd0;
  logic [15:0] digits;
  logic [3:0]  valid, err;
  logic        frame_done;

  seg7_bcd_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .s(s), .an(an),
    .digits(digits), .valid(valid), .err(err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // 0..9 decimal, 10..15 hex letters A b C d E F (all illegal to the decoder)
  logic [6:0] enc_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int checks = 0;
  int errors = 0;
  int fd_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_decode(input logic [6:0] p, output bit ok, output logic [3:0] v);
    ok = 1'b0;
    v  = 4'h0;
    if (p == 7'b0000000) begin
      ok = 1'b1;
      v  = 4'hF;
    end
    for (int i = 0; i < 10; i++)
      if (enc_tab[i] == p) begin
        ok = 1'b1;
        v  = 4'(i);
      end
  endfunction

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_err, m_seen;
  logic        m_fd;
  int          run, m_idx;
  logic [3:0]  last_an, pend_an;
  logic [6:0]  last_s, pend_s;
  bit          pend, ok, oh;
  logic [3:0]  v;

  always @(posedge clk) begin
    if (rst) begin
      m_digits = 16'hFFFF; m_valid = 0; m_err = 0; m_seen = 0; m_fd = 0;
      run = 0; last_an = 0; last_s = 0; pend = 0;
    end else begin
      m_fd = 0;
      if (pend) begin
        m_idx = 0;
        for (int i = 0; i < 4; i++) if (pend_an[i]) m_idx = i;
        model_decode(pend_s, ok, v);
        if (ok) begin
          m_digits[m_idx*4 +: 4] = v;
          m_valid[m_idx] = 1'b1;
          m_err[m_idx]   = 1'b0;
        end else begin
          m_valid[m_idx] = 1'b0;
          m_err[m_idx]   = 1'b1;
        end
        m_seen[m_idx] = 1'b1;
        if (m_seen == 4'hF) begin
          m_fd   = 1'b1;
          m_seen = 4'h0;
        end
      end
      oh = ($countones(an) == 1);
      if (oh && an == last_an && s == last_s) run++;
      else run = oh ? 1 : 0;
      last_an = an; last_s = s;
      pend = (run == S);
      pend_an = an; pend_s = s;
    end
    #1;
    chk("digits", digits, m_digits);
    chk("valid", {12'd0, valid}, {12'd0, m_valid});
    chk("err", {12'd0, err}, {12'd0, m_err});
    chk("frame_done", {15'd0, frame_done}, {15'd0, m_fd});
    if (frame_done === 1'b1) fd_total++;
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] sv, input int n);
    an = a;
    s  = sv;
    repeat (n) @(negedge clk);
  endtask

  int base;
  logic [15:0] saved;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("lit_reset_digits", digits, 16'hFFFF);
    chk("lit_reset_valid", {12'd0, valid}, 16'h0);
    chk("lit_reset_err", {12'd0, err}, 16'h0);
    chk("lit_reset_fd", {15'd0, frame_done}, 16'h0);
    rst = 1'b0;

    base = fd_total;
    hold(4'b0001, enc_tab[1], 6);
    hold(4'b0010, enc_tab[2], 6);
    hold(4'b0100, enc_tab[3], 6);
    hold(4'b1000, enc_tab[4], 6);
    chk("lit_frame_digits", digits, 16'h4321);
    chk("lit_frame_valid", {12'd0, valid}, 16'hF);
    chk("lit_frame_pulses", 16'(fd_total - base), 16'd1);

    for (int b = 0; b < 16; b++) begin
      hold(4'b0001, enc_tab[b], 6);
      if (b <= 9) begin
        chk("lit_loop_digit", {12'd0, digits[3:0]}, 16'(b));
        chk("lit_loop_valid", {15'd0, valid[0]}, 16'd1);
      end else begin
        chk("lit_loop_err", {15'd0, err[0]}, 16'd1);
        chk("lit_loop_kept", {12'd0, digits[3:0]}, 16'd9);
      end
    end

    hold(4'b0100, enc_tab[7], 3);
    chk("lit_glitch_pre", {12'd0, digits[11:8]}, 16'd3);
    hold(4'b0100, enc_tab[8], 5);
    chk("lit_glitch_post", {12'd0, digits[11:8]}, 16'd8);

    saved = digits;
    hold(4'b0000, enc_tab[5], 10);
    hold(4'b0011, enc_tab[5], 10);
    chk("lit_badan_digits", digits, saved);
    chk("lit_badan_valid", {12'd0, valid}, 16'hE);
    hold(4'b0001, enc_tab[0], 4);
    chk("lit_badan_early", {12'd0, digits[3:0]}, 16'd9);
    hold(4'b0000, 7'd0, 1);
    chk("lit_badan_cap", {12'd0, digits[3:0]}, 16'd0);
    chk("lit_badan_valid2", {12'd0, valid}, 16'hF);

    hold(4'b0010, enc_tab[5], 3);
    rst = 1'b1;
    hold(4'b0000, 7'd0, 1);
    rst = 1'b0;
    hold(4'b0000, 7'd0, 4);
    chk("lit_rstdwell_digits", digits, 16'hFFFF);
    hold(4'b0001, enc_tab[6], 6);
    hold(4'b0010, enc_tab[7], 6);
    hold(4'b0100, enc_tab[8], 6);
    rst = 1'b1;
    hold(4'b0000, 7'd0, 1);
    rst = 1'b0;
    base = fd_total;
    hold(4'b0001, enc_tab[9], 6);
    hold(4'b0010, enc_tab[8], 6);
    hold(4'b0100, enc_tab[7], 6);
    hold(4'b1000, enc_tab[6], 6);
    hold(4'b0000, 7'd0, 2);
    chk("lit_rstframe_digits", digits, 16'h6789);
    chk("lit_rstframe_pulses", 16'(fd_total - base), 16'd1);

    for (int k = 0; k < 300; k++) begin
      int r;
      logic [3:0] ra;
      logic [6:0] rs;
      r = $urandom_range(0, 9);
      if (r <= 6) ra = 4'b0001 << $urandom_range(0, 3);
      else if (r == 7) ra = 4'b0000;
      else ra = 4'b0011 << $urandom_range(0, 2);
      if ($urandom_range(0, 9) < 7) rs = enc_tab[$urandom_range(0, 9)];
      else if ($urandom_range(0, 3) == 0) rs = 7'd0;
      else rs = 7'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      hold(ra, rs, 1);
      rst = 1'b0;
      hold(ra, rs, $urandom_range(0, 7));
    end

    hold(4'b0000, 7'd0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
